// File: rtl/sprint1_ctrl_pkg.sv
// sprint1_ctrl_pkg: shared steering types and the quadrature Gray step helper
package sprint1_ctrl_pkg;

    typedef enum logic {ST_IDLE, ST_RUN} steer_state_t;

    typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} steer_dir_t;

    function automatic logic [1:0] gray_step(input logic [1:0] phase, input logic right);
        return right ? {phase[0], ~phase[1]} : {~phase[0], phase[1]};
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for an asynchronous level input
module sync2 (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk_sys or negedge rst_n)
        if (!rst_n) {q, meta} <= 2'b00;
        else        {q, meta} <= {meta, d};

endmodule

// File: rtl/steer_quad_encoder.sv
// steer_quad_encoder: held left/right requests to quadrature steps that speed up while held
// STEER_RAMP_EN enables the interval ramp; otherwise every interval is DIV_SLOW
module steer_quad_encoder
    import sprint1_ctrl_pkg::*;
#(
    parameter int DIV_SLOW  = 24000,
    parameter int DIV_FAST  = 6000,
    parameter int RAMP_STEP = 2000
) (
    input  logic Clk_I,
    input  logic Reset_n,
    input  logic Left_I,
    input  logic Right_I,
    output logic SteerA_O,
    output logic SteerB_O,
    output logic Moving_O,
    output logic Dir_O
);
    localparam int CW = $clog2(DIV_SLOW + 1);

    logic          left_s, right_s, req_right, restart;
    steer_dir_t    req;
    steer_state_t  state, state_nxt;
    logic [1:0]    phase, phase_nxt;
    logic          dir, dir_nxt;
    logic [CW-1:0] cnt, cnt_nxt, nd;

    sync2 u_sync_l (.clk_sys(Clk_I), .rst_n(Reset_n), .d(Left_I),  .q(left_s));
    sync2 u_sync_r (.clk_sys(Clk_I), .rst_n(Reset_n), .d(Right_I), .q(right_s));

    assign req       = (right_s && !left_s) ? DIR_RIGHT : (left_s && !right_s) ? DIR_LEFT : DIR_NONE;
    assign req_right = (req == DIR_RIGHT);
    // a fresh press or a reversal both restart the turn with an immediate step
    assign restart   = (req != DIR_NONE) && (state == ST_IDLE || req_right != dir);

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        dir_nxt   = dir;
        cnt_nxt   = cnt;
        if (req == DIR_NONE)
            state_nxt = ST_IDLE;
        else if (restart) begin
            state_nxt = ST_RUN;
            phase_nxt = gray_step(phase, req_right);
            dir_nxt   = req_right;
            cnt_nxt   = CW'(DIV_SLOW - 1);
        end else if (cnt != '0)
            cnt_nxt = cnt - CW'(1);
        else begin
            phase_nxt = gray_step(phase, dir);
            cnt_nxt   = nd - CW'(1);
        end
    end

    always_ff @(posedge Clk_I or negedge Reset_n)
        if (!Reset_n) begin
            state <= ST_IDLE;
            phase <= 2'b00;
            dir   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            dir   <= dir_nxt;
            cnt   <= cnt_nxt;
        end

`ifdef STEER_RAMP_EN
    logic [CW-1:0] cur_div;
    logic [CW:0]   diff;

    // one bit wider so a large RAMP_STEP borrows instead of wrapping
    assign diff = {1'b0, cur_div} - (CW+1)'(RAMP_STEP);
    assign nd   = (diff[CW] || diff[CW-1:0] < CW'(DIV_FAST)) ? CW'(DIV_FAST) : diff[CW-1:0];

    always_ff @(posedge Clk_I or negedge Reset_n)
        if (!Reset_n)                          cur_div <= CW'(DIV_SLOW);
        else if (restart)                      cur_div <= CW'(DIV_SLOW);
        else if (req != DIR_NONE && cnt == '0) cur_div <= nd;
`else
    logic [31:0] unused_cfg;

    assign unused_cfg = DIV_FAST + RAMP_STEP;
    assign nd         = CW'(DIV_SLOW);
`endif

    assign SteerA_O = phase[1];
    assign SteerB_O = phase[0];
    assign Moving_O = (state == ST_RUN);
    assign Dir_O    = dir;

endmodule

// File: tb/tb_steer_quad_encoder.sv
// tb_steer_quad_encoder: segment-table checks of stepping, ramp, reversal and reset
module tb_steer_quad_encoder;

    logic clk = 1'b0;
    logic Reset_n, Left_I, Right_I;
    logic SteerA_O, SteerB_O, Moving_O, Dir_O;

    typedef struct {
        logic       l, r;
        int         n;
        logic [1:0] ph;
        logic       mov, dir;
    } seg_t;

    seg_t       tbl[$];
    int         iv[6];
    logic [1:0] ph;
    string      tname;
    int         compared = 0, mismatched = 0;

    steer_quad_encoder #(.DIV_SLOW(8), .DIV_FAST(2), .RAMP_STEP(2)) dut (
        .Clk_I(clk), .Reset_n(Reset_n), .Left_I(Left_I), .Right_I(Right_I),
        .SteerA_O(SteerA_O), .SteerB_O(SteerB_O), .Moving_O(Moving_O), .Dir_O(Dir_O)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    function automatic logic [1:0] nxt(input logic [1:0] p, input logic right);
        case (p)
            2'b00:   return right ? 2'b01 : 2'b10;
            2'b01:   return right ? 2'b11 : 2'b00;
            2'b11:   return right ? 2'b10 : 2'b01;
            default: return right ? 2'b00 : 2'b11;
        endcase
    endfunction

    task automatic check(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s[%0d]: {A,B,Moving,Dir} got %b want %b", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic l, input logic r, input int n, input logic [1:0] p,
                       input logic mov, input logic dir);
        seg_t s;
        s.l = l; s.r = r; s.n = n; s.ph = p; s.mov = mov; s.dir = dir;
        tbl.push_back(s);
    endtask

    task automatic held(input logic l, input logic r, input int k, input logic dir);
        for (int j = 0; j < k; j++) begin
            add(l, r, iv[j] - 1, ph, 1'b1, dir);
            ph = nxt(ph, r);
            add(l, r, 1, ph, 1'b1, dir);
        end
    endtask

    task automatic run();
        for (int i = 0; i < tbl.size(); i++) begin
            Left_I  = tbl[i].l;
            Right_I = tbl[i].r;
            repeat (tbl[i].n) @(posedge clk);
            #1;
            check(tname, i, {SteerA_O, SteerB_O, Moving_O, Dir_O}, {tbl[i].ph, tbl[i].mov, tbl[i].dir});
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        Reset_n = 1'b0;
        Left_I  = 1'b0;
        Right_I = 1'b0;
        #1;
        check("rst", 0, {SteerA_O, SteerB_O, Moving_O, Dir_O}, 4'b0000);
        @(posedge clk);
        #1;
        Reset_n = 1'b1;
    endtask

    initial begin
`ifdef STEER_RAMP_EN
        iv = '{8, 6, 4, 2, 2, 2};
`else
        iv = '{8, 8, 8, 8, 8, 8};
`endif
        Reset_n = 1'b0;
        Left_I  = 1'b0;
        Right_I = 1'b0;

        tname = "in_reset";
        add(1, 0, 1, 2'b00, 0, 0);
        add(0, 1, 3, 2'b00, 0, 0);
        add(1, 1, 1, 2'b00, 0, 0);
        add(0, 1, 4, 2'b00, 0, 0);
        run();
        @(posedge clk);
        #1;
        Right_I = 1'b0;
        Reset_n = 1'b1;
        tname = "released";
        add(0, 0, 4, 2'b00, 0, 0);
        run();

        tname = "right";
        do_reset();
        add(0, 1, 2, 2'b00, 0, 0);
        add(0, 1, 1, 2'b01, 1, 1);
        ph = 2'b01;
        held(0, 1, 6, 1'b1);
        run();

        tname = "left";
        do_reset();
        add(1, 0, 2, 2'b00, 0, 0);
        add(1, 0, 1, 2'b10, 1, 0);
        ph = 2'b10;
        held(1, 0, 6, 1'b0);
        run();

        tname = "both_then_release";
        do_reset();
        add(1, 1, 25, 2'b00, 0, 0);
        add(1, 1, 25, 2'b00, 0, 0);
        add(0, 1, 2, 2'b00, 0, 0);
        add(0, 1, 1, 2'b01, 1, 1);
        add(0, 0, 2, 2'b01, 1, 1);
        add(0, 0, 1, 2'b01, 0, 1);
        add(0, 0, 10, 2'b01, 0, 1);
        run();

        tname = "reversal";
        do_reset();
        add(0, 1, 2, 2'b00, 0, 0);
        add(0, 1, 1, 2'b01, 1, 1);
        ph = 2'b01;
        held(0, 1, 4, 1'b1);
`ifdef STEER_RAMP_EN
        add(1, 0, 1, 2'b01, 1, 1);
        add(1, 0, 1, 2'b11, 1, 1);
        add(1, 0, 1, 2'b01, 1, 0);
        add(1, 0, 7, 2'b01, 1, 0);
        add(1, 0, 1, 2'b00, 1, 0);
`else
        add(1, 0, 2, 2'b01, 1, 1);
        add(1, 0, 1, 2'b00, 1, 0);
        add(1, 0, 7, 2'b00, 1, 0);
        add(1, 0, 1, 2'b10, 1, 0);
`endif
        run();

        tname = "async_reset";
        do_reset();
        add(0, 1, 2, 2'b00, 0, 0);
        add(0, 1, 1, 2'b01, 1, 1);
        add(0, 1, 5, 2'b01, 1, 1);
        run();
        #3;
        Reset_n = 1'b0;
        #1;
        check("async_now", 0, {SteerA_O, SteerB_O, Moving_O, Dir_O}, 4'b0000);
        @(posedge clk);
        #1;
        check("async_held", 0, {SteerA_O, SteerB_O, Moving_O, Dir_O}, 4'b0000);
        Reset_n = 1'b1;
        tname = "after_reset";
        add(0, 1, 2, 2'b00, 0, 0);
        add(0, 1, 1, 2'b01, 1, 1);
        ph = 2'b01;
        held(0, 1, 1, 1'b1);
        run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
